// File: rtl/vending_machine.sv
// Single-product vending controller.
// Accepts one coin code per clock and accumulates credit in Rs.5 units
// against the price of the item latched with the first coin. When credit
// meets or exceeds the price, it issues the product and change codes for
// exactly one cycle.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | no transaction open; the first coin latches choice
// ST_COLLECT  | credit below price; further coins add to credit
// ST_DISPENSE | prd/chng valid for this one cycle; coins are ignored
module vending_machine (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] choice,
   input  logic [1:0] in_mny,
   output logic [2:0] prd,
   output logic [1:0] chng
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COLLECT  = 2'd1,
      ST_DISPENSE = 2'd2
   } state_t;

   localparam logic [1:0] MNY_NONE = 2'b00;
   localparam logic [1:0] MNY_RS5  = 2'b01;
   localparam logic [1:0] MNY_RS10 = 2'b10;
   localparam logic [1:0] MNY_RS20 = 2'b11;

   // Registers start at their reset values so outputs are defined
   // before the first reset edge.
   state_t     state_q  = ST_IDLE;
   logic [2:0] credit_q = 3'd0;
   logic [1:0] item_q   = 2'b00;
   logic [2:0] prd_q    = 3'b000;
   logic [1:0] chng_q   = 2'b00;

   state_t     state_d;
   logic [2:0] credit_d;
   logic [1:0] item_d;
   logic [2:0] prd_d;
   logic [1:0] chng_d;

   logic [2:0] coin_units;
   logic [1:0] sel_item;
   logic [3:0] price_units;
   logic [3:0] base_units;
   logic [3:0] sum_units;
   logic       coin_valid;
   logic       paid;

   // Coin value, active item price and running sum in Rs.5 units.
   always_comb begin
      coin_units = 3'd0;
      case (in_mny)
         MNY_RS5:  coin_units = 3'd1;
         MNY_RS10: coin_units = 3'd2;
         MNY_RS20: coin_units = 3'd4;
         default:  coin_units = 3'd0;
      endcase

      // In IDLE the first coin is about to latch choice, so price from it
      // directly; afterwards the latched item is authoritative.
      sel_item    = (state_q == ST_IDLE) ? choice : item_q;
      price_units = {2'b00, sel_item} + 4'd1;
      base_units  = (state_q == ST_COLLECT) ? {1'b0, credit_q} : 4'd0;
      sum_units   = base_units + {1'b0, coin_units};
      coin_valid  = (in_mny != MNY_NONE);
      paid        = (sum_units >= price_units);
   end

   // Next-state and registered-output decode.
   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      item_d   = item_q;
      prd_d    = 3'b000;
      chng_d   = 2'b00;

      case (state_q)
         ST_IDLE: begin
            if (coin_valid) begin
               item_d = choice;
               if (paid) begin
                  state_d  = ST_DISPENSE;
                  credit_d = 3'd0;
                  prd_d    = {1'b1, choice};
                  chng_d   = 2'(sum_units - price_units);
               end else begin
                  state_d  = ST_COLLECT;
                  credit_d = sum_units[2:0];
               end
            end
         end

         ST_COLLECT: begin
            if (coin_valid) begin
               if (paid) begin
                  state_d  = ST_DISPENSE;
                  credit_d = 3'd0;
                  prd_d    = {1'b1, item_q};
                  chng_d   = 2'(sum_units - price_units);
               end else begin
                  credit_d = sum_units[2:0];
               end
            end
         end

         ST_DISPENSE: begin
            // Coins seen here are dropped; the next transaction starts clean.
            state_d  = ST_IDLE;
            credit_d = 3'd0;
         end

         default: begin
            state_d  = ST_IDLE;
            credit_d = 3'd0;
         end
      endcase
   end

   // State, credit, latched item and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         credit_q <= 3'd0;
         item_q   <= 2'b00;
         prd_q    <= 3'b000;
         chng_q   <= 2'b00;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         item_q   <= item_d;
         prd_q    <= prd_d;
         chng_q   <= chng_d;
      end
   end

   assign prd  = prd_q;
   assign chng = chng_q;

endmodule

// File: tb/tb_vending_machine.sv
// Self-checking bench for vending_machine: directed scenarios followed by
// random coin/choice/reset traffic, compared against a rupee-level model.
module tb_vending_machine;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] choice = 2'b00;
   logic [1:0] in_mny = 2'b00;
   logic [2:0] prd;
   logic [1:0] chng;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Reference model state, kept in rupees.
   int m_credit_rs = 0;
   bit m_open      = 1'b0;
   bit m_disp      = 1'b0;
   int m_item      = 0;
   int m_prd       = 0;
   int m_chng      = 0;

   vending_machine dut (
      .clk    (clk),
      .rst    (rst),
      .choice (choice),
      .in_mny (in_mny),
      .prd    (prd),
      .chng   (chng)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      vec_cnt++;
      if (obs != exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int coin_rs(input int code);
      case (code)
         1:       return 5;
         2:       return 10;
         3:       return 20;
         default: return 0;
      endcase
   endfunction

   // One clock edge of the transaction rules, expressed in rupees.
   task automatic model_step(input bit r, input int ch, input int mny);
      int total;
      int price;
      m_prd  = 0;
      m_chng = 0;
      if (r) begin
         m_credit_rs = 0;
         m_open      = 1'b0;
         m_disp      = 1'b0;
      end else if (m_disp) begin
         m_disp = 1'b0;
      end else if (mny != 0) begin
         if (!m_open) m_item = ch;
         price = (m_item + 1) * 5;
         total = m_credit_rs + coin_rs(mny);
         if (total >= price) begin
            m_prd       = 4 + m_item;
            m_chng      = (total - price) / 5;
            m_credit_rs = 0;
            m_open      = 1'b0;
            m_disp      = 1'b1;
         end else begin
            m_credit_rs = total;
            m_open      = 1'b1;
         end
      end
   endtask

   // Drive one cycle of inputs, clock it, and compare against the model.
   task automatic apply(input bit r, input logic [1:0] ch, input logic [1:0] mny, input string tag);
      rst    = r;
      choice = ch;
      in_mny = mny;
      @(posedge clk);
      #1;
      model_step(r, int'(ch), int'(mny));
      chk({tag, "_prd"}, int'(prd), m_prd);
      chk({tag, "_chng"}, int'(chng), m_chng);
   endtask

   initial begin
      #1;
      chk("pwrup_prd", int'(prd), 0);
      chk("pwrup_chng", int'(chng), 0);

      // Idle edges without reset, then a dispense with a coin in the
      // DISPENSE cycle that must not carry into the next transaction.
      apply(1'b0, 2'b11, 2'b00, "pre_idle");
      apply(1'b0, 2'b11, 2'b11, "pre_pay");
      chk("pre_pay_const", int'(prd), 3'b111);
      apply(1'b0, 2'b11, 2'b10, "disp_coin");
      chk("disp_coin_const", int'(prd), 0);
      apply(1'b0, 2'b11, 2'b10, "after_disp");
      chk("no_carry_const", int'(prd), 0);
      apply(1'b1, 2'b00, 2'b00, "rst0");

      // Rs.20 paid as 10, 5, 10 -> Rs.5 change.
      apply(1'b0, 2'b11, 2'b10, "tp1_a");
      apply(1'b0, 2'b11, 2'b01, "tp1_b");
      apply(1'b0, 2'b11, 2'b10, "tp1_c");
      chk("tp1_prd_const", int'(prd), 3'b111);
      chk("tp1_chng_const", int'(chng), 2'b01);
      apply(1'b0, 2'b11, 2'b00, "tp1_d");

      // Rs.5 paid with Rs.20 -> Rs.15 change.
      apply(1'b0, 2'b00, 2'b11, "tp2_a");
      chk("tp2_chng_const", int'(chng), 2'b11);
      apply(1'b0, 2'b00, 2'b00, "tp2_b");

      // Rs.10 with an idle gap between coins.
      apply(1'b0, 2'b01, 2'b01, "tp3_a");
      apply(1'b0, 2'b01, 2'b00, "tp3_b");
      apply(1'b0, 2'b01, 2'b01, "tp3_c");
      chk("tp3_prd_const", int'(prd), 3'b101);
      apply(1'b0, 2'b01, 2'b00, "tp3_d");

      // Choice changed mid-transaction is ignored.
      apply(1'b0, 2'b10, 2'b10, "tp4_a");
      apply(1'b0, 2'b00, 2'b10, "tp4_b");
      chk("tp4_prd_const", int'(prd), 3'b110);
      chk("tp4_chng_const", int'(chng), 2'b01);
      apply(1'b0, 2'b00, 2'b00, "tp4_c");

      // Reset with a coin on the same edge discards credit.
      apply(1'b0, 2'b11, 2'b10, "tp5_a");
      apply(1'b1, 2'b11, 2'b10, "tp5_rst");
      apply(1'b0, 2'b11, 2'b10, "tp5_b");
      chk("tp5_b_const", int'(prd), 0);
      apply(1'b0, 2'b11, 2'b10, "tp5_c");
      chk("tp5_prd_const", int'(prd), 3'b111);
      chk("tp5_chng_const", int'(chng), 0);
      apply(1'b0, 2'b11, 2'b00, "tp5_d");

      // Random traffic with occasional resets.
      for (int i = 0; i < 2000; i++) begin
         apply(($urandom_range(0, 39) == 0),
               2'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)),
               "rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
